// File: rtl/stdout_fifo_pkg.sv
// Shared types for the stdout byte buffer.
// Holds the transmit state encoding and default depth.
package stdout_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/stdout_fifo_if.sv
// Start/ready handshake between the stdout buffer and uart_tx.
// master drives the byte and start; slave answers with ready.
interface stdout_fifo_if;

    logic [7:0] uart_data;
    logic       uart_start;
    logic       uart_ready;

    modport master (
        output uart_data,
        output uart_start,
        input  uart_ready
    );

    modport slave (
        input  uart_data,
        input  uart_start,
        output uart_ready
    );

endinterface

// File: rtl/stdout_fifo_sync_fifo.sv
// Single-clock byte FIFO with registered pop data.
// Pushes while full are dropped and latch a sticky overflow.
module sync_fifo
    import stdout_fifo_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count_n;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_ok = push & ~full;
    assign rd_ok = pop & ~empty;

    always_comb begin
        count_n = count;
        if (wr_ok && !rd_ok)
            count_n = count + 1'b1;
        else if (!wr_ok && rd_ok)
            count_n = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dout     <= '0;
        end else begin
            count <= count_n;
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (push && full)
                overflow <= 1'b1;
            if (rd_ok) begin
                dout <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/stdout_fifo.sv
// Buffers proc stdout bytes and meters them into uart_tx.
// Rising stdout_en pushes one byte; a small FSM pops and hands off.
module stdout_fifo
    import stdout_fifo_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    stdout,
    input  logic          stdout_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    stdout_fifo_if.master uart
);

    tx_state_t  state;
    tx_state_t  state_n;
    logic       en_q;
    logic       push;
    logic       pop;
    logic [7:0] pop_data;

    assign push = stdout_en & ~en_q;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      (stdout),
        .pop      (pop),
        .dout     (pop_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q  <= 1'b0;
            state <= IDLE;
        end else begin
            en_q  <= stdout_en;
            state <= state_n;
        end
    end

    // Pop only on IDLE->START so uart_data stays put until the next byte.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && uart.uart_ready) begin
                    state_n = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (!uart.uart_ready)
                    state_n = BUSY;
            end
            BUSY: begin
                if (uart.uart_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign uart.uart_start = (state == START);
    assign uart.uart_data  = pop_data;

endmodule

// File: doc/stdout_fifo.md
Name: stdout_fifo

Overview:
- Buffers bytes the proc emits on its stdout/stdout_en pair and meters them into uart_tx over a start/ready handshake.
- Replaces the ad-hoc start/ongoing logic in the top level.
- Lets the CPU emit bursts of characters while the UART drains at 115200 baud.
- Sits between proc (upstream) and uart_tx (downstream), in the uart_tx clock domain.

Parameters:
- DEPTH, 16, FIFO entries. Must be a power of two, 2..256.
- AW, $clog2(DEPTH), pointer width. Derived; never overridden.

Ports:
- clk  input  1  the single clock; every register samples on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stdout  input  8  byte from proc. Valid while stdout_en is high.
- stdout_en  input  1  level from proc. Each 0->1 transition is one output request.
- full  output  1  high when count==DEPTH. Proc may use it to stall.
- empty  output  1  high when count==0.
- count  output  AW+1  number of buffered bytes.
- overflow  output  1  sticky. Set when a request arrives while full.
- uart_data  output  8  byte currently being transmitted. Stable from START until the next pop.
- uart_start  output  1  transmit request to uart_tx.
- uart_ready  input  1  uart_tx idle indication.

Behaviour:
- Reset values: full=0, empty=1, count=0, overflow=0, uart_data=0x00, uart_start=0, state=IDLE.
- Reset is honoured mid-transmit: state is forced to IDLE, FIFO contents are discarded, and uart_start drops on the next edge.
- Edge detect:
  - en_q is a registered copy of stdout_en (reset value 0).
  - push = stdout_en & ~en_q. The byte is sampled on that same edge.
  - A level held for N cycles produces exactly one push.
- Push:
  - Accepted iff full==0, judged on the registered count before this edge.
  - Writes mem[wptr] and increments wptr (mod DEPTH, natural wrap).
  - A push while full drops the byte, sets overflow, and leaves pointers unchanged.
  - overflow clears only on reset.
- Pop:
  - Occurs only on the IDLE->START transition.
  - Loads uart_data<=mem[rptr] and increments rptr (mod DEPTH).
- Simultaneous push and pop in one cycle: both occur and count is unchanged. Push acceptance is still judged on the pre-edge full, so a push is dropped even if a pop happens on the same edge while full.
- count width is AW+1 so that DEPTH itself is representable. full and empty are decoded from count.
- Transmit FSM:
  - IDLE: if !empty && uart_ready -> START. Perform pop; uart_start<=1.
  - START: hold uart_start=1 until uart_ready==0 (uart_tx has accepted), then -> BUSY with uart_start<=0. No timeout: if ready never drops, the FSM stays in START.
  - BUSY: when uart_ready==1 -> IDLE.
- Latency:
  - A push sampled at edge k makes empty=0 after edge k.
  - With uart_ready high, uart_start=1 and uart_data valid after edge k+1.
- Back-to-back bytes: after BUSY->IDLE, the next pop happens on the following edge if the FIFO is non-empty. There is a minimum of 1 idle cycle between a ready rise and the next start.
- uart_data is held after BUSY, so the line value is never disturbed.

Decomposition:
- Shared package holds:
  - the state enum: IDLE=2'd0, START=2'd1, BUSY=2'd2;
  - DEFAULT_DEPTH=16.
- One sub-module: sync_fifo.
  - Contains mem, wptr, rptr, count, full, empty, and overflow logic.
  - push/pop interface; pop data is registered.
- The top of the block keeps the edge detect and the transmit FSM.

Test Plan:
- Single char: stdout=0x48, stdout_en high 5 cycles, uart_ready=1 -> exactly one uart_start rise with uart_data=0x48. Model drops ready 1 cycle after start, raises it 20 cycles later -> FIFO empty, FSM in IDLE.
- Burst: pushes 0x41,0x42,0x43 on cycles 2,4,6 while the UART model is busy -> count reaches 3. Transmitted in order 0x41,0x42,0x43; uart_start is asserted once per byte.
- Overflow: uart_ready=0 for the whole fill; 17 pushes with DEPTH=16 -> full=1, count=16, overflow=1. 17th byte absent. On drain, 16 bytes come out in order.
- Wrap: 40 pushes interleaved with drains -> pointers wrap twice. Output sequence equals input sequence; count never exceeds 16.
- Stuck ready: uart_ready held high after start -> FSM stays in START with uart_start=1 and no further pops.
- Reset mid-transmit: reset=1 for one cycle while in BUSY with count=5 -> next cycle count=0, empty=1, uart_start=0, overflow=0, state IDLE. No stale bytes are sent afterwards.
